single_port_ram: RTL and testbench

//   Synchronous single-port RAM: one shared address, one write port and one registered read port.

---
 rtl/single_port_ram_pkg.sv | 27 ++
 rtl/single_port_ram.sv | 55 +++++
 tb/tb_single_port_ram.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/single_port_ram_pkg.sv
// Shared definitions for the single-port RAM.
// Holds the default geometry. It also decodes the en/wr pair into one access
// operation, so the storage block can branch on what the cycle does rather
// than on raw control bits.
package single_port_ram_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultAddrW = 3;

  typedef enum logic [1:0] {
    OpIdle  = 2'b00,
    OpWrite = 2'b01,
    OpRead  = 2'b10
  } ram_op_e;

  // en gates everything; wr only selects the direction of an enabled access.
  function automatic ram_op_e decode_op(input logic en, input logic wr);
    if (!en) begin
      return OpIdle;
    end else if (wr) begin
      return OpWrite;
    end else begin
      return OpRead;
    end
  endfunction

endpackage

// File: rtl/single_port_ram.sv
// Synchronous single-port RAM with a registered read port.
// It has one shared address for reads and writes. A read returns the word
// stored before the edge, one cycle later. A write leaves data_out unchanged.
// An asynchronous active-low reset clears every word and the output register.
//
// Ports:
//   clk       clock; all state updates on its rising edge
//   rstn      asynchronous active-low reset
//   data_in   write data
//   wr        1 = write, 0 = read; only meaningful when en = 1
//   en        access enable; 0 = idle cycle
//   addr      word address shared by read and write
//   data_out  registered read data
module single_port_ram
  import single_port_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  ram_op_e           op;

  always_comb begin
    op = decode_op(en, wr);
  end

  // Memory and output share one process so that a reset aborts any access in
  // flight. No partial write can survive a reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (op)
        OpWrite: mem[addr] <= data_in;
        OpRead:  data_out  <= mem[addr];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_single_port_ram.sv
// Self-checking bench for single_port_ram.
// A reference model built on plain arrays tracks the expected memory and the
// expected output. Directed steps come first, then randomized traffic with
// occasional asynchronous reset pulses.
module tb_single_port_ram;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned NW = 1 << AW;

  logic          clk;
  logic          rstn;
  logic [DW-1:0] data_in;
  logic          wr;
  logic          en;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;

  int vectors;
  int miscompares;

  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] ref_out;

  single_port_ram #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .data_in  (data_in),
    .wr       (wr),
    .en       (en),
    .addr     (addr),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NW); i++) ref_mem[i] = '0;
    ref_out = '0;
  endtask

  // Drive on the falling edge, apply the model at the rising edge, then settle.
  task automatic cycle(input logic e, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    @(negedge clk);
    en      = e;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    if (e && w) ref_mem[a] = d;
    else if (e) ref_out = ref_mem[a];
    #1;
  endtask

  // Reset pulse placed between edges; output must clear without a clock.
  task automatic reset_pulse();
    @(negedge clk);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    check("async_reset_out", data_out, 8'h00);
    #1;
    rstn = 1'b1;
  endtask

  logic [DW-1:0] pattern [NW];

  initial begin
    vectors     = 0;
    miscompares = 0;
    en          = 1'b0;
    wr          = 1'b0;
    addr        = '0;
    data_in     = '0;
    rstn        = 1'b1;
    model_reset();
    pattern = '{8'hAA, 8'hF0, 8'hCC, 8'h33, 8'h0F, 8'h55, 8'h95, 8'hFF};

    // 1. Hold reset across rising edges, with activity on the inputs.
    #1 rstn = 1'b0;
    en = 1'b1;
    wr = 1'b1;
    data_in = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_out", data_out, 8'h00);

    // 2. Release with en = 0 for one cycle.
    @(negedge clk);
    en = 1'b0;
    rstn = 1'b1;
    cycle(1'b0, 1'b1, 3'd4, 8'h99);
    check("idle_after_release", data_out, ref_out);

    // Every word reads back zero after reset.
    for (int i = 0; i < int'(NW); i++) begin
      cycle(1'b1, 1'b0, AW'(i), 8'h00);
      check($sformatf("reset_word%0d", i), data_out, 8'h00);
    end

    // 3. Writes: no write-through, so the output holds its last value.
    for (int i = 0; i < int'(NW); i++) begin
      cycle(1'b1, 1'b1, AW'(i), pattern[i]);
      check($sformatf("write_hold%0d", i), data_out, 8'h00);
    end

    // 4. Back-to-back reads.
    for (int i = 0; i < int'(NW); i++) begin
      cycle(1'b1, 1'b0, AW'(i), 8'h00);
      check($sformatf("read%0d", i), data_out, pattern[i]);
    end

    // 5. A disabled write is ignored, and the output holds during that cycle.
    cycle(1'b0, 1'b1, 3'd2, 8'h77);
    check("en0_hold", data_out, 8'hFF);
    cycle(1'b1, 1'b0, 3'd2, 8'h00);
    check("en0_write_ignored", data_out, 8'hCC);

    // A read right after a write to the same address returns the new data.
    cycle(1'b1, 1'b1, 3'd5, 8'h3C);
    check("wr_no_through", data_out, 8'hCC);
    cycle(1'b1, 1'b0, 3'd5, 8'h00);
    check("read_after_write", data_out, 8'h3C);

    // 6. Async reset pulse between edges, then the memory is cleared.
    reset_pulse();
    cycle(1'b1, 1'b0, 3'd7, 8'h00);
    check("post_reset_addr7", data_out, 8'h00);
    cycle(1'b1, 1'b0, 3'd0, 8'h00);
    check("post_reset_addr0", data_out, 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset_pulse();
      end else begin
        cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, NW - 1)), DW'($urandom));
        check("random", data_out, ref_out);
      end
    end

    // Final sweep of memory contents.
    for (int i = 0; i < int'(NW); i++) begin
      cycle(1'b1, 1'b0, AW'(i), 8'h00);
      check($sformatf("sweep%0d", i), data_out, ref_mem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
